chunk_row_arbiter: RTL and testbench
====================================

# chunk_row_arbiter

Round-robin arbiter that shares one chunk row-start generator among `N_REQ` requesting read pipelines. It accepts one chunk command per grant and registers that requester's chunk geometry. It then drives the generator's `mofs` handshake and config inputs, and tags every emitted row with the owning requester id. The grant is held until the generator's last row of the chunk is accepted. The block sits between the per-pipeline chunk address loopers and the shared row-start generator inside the tile accumulation unit's read path.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, at least 1.
- `GBW`, default `TauCfg::GLOBAL_ADDR_BW`: global address width.
- `DIM`, default `TauCfg::DIM`: number of dimensions.
- `V_BW`, default `$clog2(TauCfg::VECTOR_SIZE)`: pad field width.
- `IBW`, default `$clog2(N_REQ)`, or 1 when `N_REQ`=1: id width.

Ports (name, direction, width, meaning):
- `i_clk` in 1: the block's one clock.
- `i_rst` in 1: reset, asynchronous, active-low.
- `req_rdy` in `[N_REQ]`: requester i has a chunk command.
- `req_ack` out `[N_REQ]`: command i accepted this cycle.
- `i_req_mofs` in `GBW x [N_REQ][DIM]`: chunk offset per dimension.
- `i_req_mpad` in `V_BW x [N_REQ][DIM]`: pad per dimension.
- `i_req_mbound` in `GBW x [N_REQ][DIM]`: bound per dimension.
- `i_req_mlast` in `GBW x [N_REQ][DIM]`: last index per dimension.
- `i_req_maddr` in `GBW x [N_REQ]`: chunk base linear address.
- `mofs_rdy` out 1: command valid toward the generator.
- `mofs_ack` in 1: generator accepted the command.
- `o_mofs`, `o_mpad`, `o_mbound`, `o_mlast`, `o_maddr` out: registered config of the granted command, same widths without the `[N_REQ]` index.
- `row_rdy` in 1: generator row valid (snooped only).
- `row_ack` in 1: downstream accepted the row (snooped only).
- `i_row_islast` in 1: generator's last-row flag.
- `o_row_id` out `IBW`: id of the current owner.
- `o_busy` out 1: the generator is owned.

## Operation
- Handshake rule: a transfer occurs when `rdy && ack` in the same cycle. `ack` is only asserted while `rdy` is high.
- FSM states are IDLE, ISSUE and BUSY. `o_busy` is high in ISSUE and BUSY.
- IDLE:
  - Combinational round-robin pick among `req_rdy`, starting at index `ptr`.
  - Assert `req_ack` for the winner only.
  - On that cycle, latch the winner's config into the `o_*` registers, set `o_row_id` to the winner, set `ptr` to (winner+1) mod `N_REQ`, and go to ISSUE.
  - With no requests, stay in IDLE with all `req_ack` low.
- ISSUE:
  - `mofs_rdy`=1.
  - On `mofs_ack`, go to BUSY.
  - `mofs_rdy` never drops before `mofs_ack`.
- BUSY:
  - On `row_rdy && row_ack && i_row_islast`, go to IDLE.
  - Non-last rows keep the state.
- The `o_*` config registers and `o_row_id` are held constant from the latch until the next grant.
- A row handshake observed in IDLE or ISSUE is ignored. It must not change state.
- All `req_ack` are forced to 0 while `i_rst` is low.

## Timing
- Reset values:
  - State IDLE, `ptr`=0.
  - `mofs_rdy`=0, `o_busy`=0, `o_row_id`=0.
  - All `o_*` config registers are 0.
- Grant latency: `req_rdy` high in IDLE gives `req_ack` in the same cycle, then `mofs_rdy`=1 on the next cycle.
- Release: a last-row ack at cycle t gives IDLE at t+1, and the next `req_ack` is possible at t+1.
  - Minimum gap between the final row of one chunk and the next `mofs_rdy` is 2 cycles.
- Simultaneous requests: exactly one `req_ack` per grant, and no starvation.
  - With all `N_REQ` requesters continuously requesting, each is granted once per `N_REQ` grants.
- Single-row chunk: the first row has `i_row_islast`=1, so BUSY lasts exactly until that row's ack.
- A requester dropping `req_rdy` in IDLE before being acked is removed from arbitration that cycle.
- Reset mid-chunk returns the block to the reset values. The generator shares the same reset.

## Structure
- Shared constants (`GLOBAL_ADDR_BW`, `DIM`, `VECTOR_SIZE`) come from `TauCfg`.
- The FSM state enum (IDLE/ISSUE/BUSY) goes into `TauCfg` as a shared typedef, for reuse by other arbiters.
- One sub-module, `RoundRobinPick#(N_REQ)`:
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant, encoded id, and an any-request flag.
  - Purely combinational.

## Test plan
- Reset, then `req_rdy[0]`=1 with `maddr`=0x100 and `mlast`={1,2} → `req_ack[0]` in cycle 0; `mofs_rdy`=1 and `o_maddr`=0x100 in cycle 1; `o_row_id`=0.
- `N_REQ`=2, both requesting continuously, generator gives 3-row chunks → grants alternate 0,1,0,1; `o_row_id` changes only after each last-row ack.
- Hold `mofs_ack`=0 for 5 cycles → `mofs_rdy` stays 1 and `o_*` stay stable; ack on cycle 6 gives BUSY.
- Single-row chunk (`islast` on the first row, `row_ack` delayed 3 cycles) → IDLE exactly 1 cycle after the ack; the next grant is issued that cycle.
- Spurious `row_rdy && row_ack && islast` while in ISSUE → state unchanged and `mofs_rdy` still 1.
- Assert `i_rst` low in BUSY mid-chunk → all outputs reach reset values asynchronously; after release, `ptr`=0 so requester 0 wins a tie.

Source files
------------

// File: rtl/chunk_row_arbiter_pkg.sv
// TauCfg: shared constants for the tile accumulation unit, plus the
// arbiter state enum reused by every generator-sharing arbiter.
package TauCfg;

  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DIM            = 2;
  localparam int VECTOR_SIZE    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/chunk_row_arbiter_pick.sv
// RoundRobinPick: combinational round-robin selection.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index that has highest priority this cycle
//   grant - one-hot winner (all zero when no request)
//   id    - encoded winner index
//   any   - at least one request is present
module RoundRobinPick #(
  parameter int N_REQ = 2,
  parameter int IBW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IBW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IBW-1:0]   id,
  output logic             any
);

  int idx;

  // Scan from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = IBW'(idx);
      end
    end
  end

endmodule

// File: rtl/chunk_row_arbiter.sv
// chunk_row_arbiter: shares one chunk row-start generator among N_REQ
// read pipelines. A granted requester's chunk geometry is registered and
// presented to the generator; the grant is held until the generator's
// last row of the chunk is accepted downstream.
// Ports:
//   i_clk, i_rst       - clock, async active-low reset
//   req_rdy / req_ack  - per-requester command handshake
//   i_req_*            - per-requester chunk geometry
//   mofs_rdy/mofs_ack  - command handshake toward the generator
//   o_m*               - registered geometry of the granted command
//   row_rdy, row_ack, i_row_islast - snooped generator row handshake
//   o_row_id           - id of the current owner
//   o_busy             - generator is owned
//
// state    | meaning
// ST_IDLE  | arbitrating; winner acked and latched in the same cycle
// ST_ISSUE | command offered to the generator, waiting for mofs_ack
// ST_BUSY  | generator emitting rows, waiting for the last-row handshake
module chunk_row_arbiter
  import TauCfg::*;
#(
  parameter int N_REQ = 2,
  parameter int GBW   = TauCfg::GLOBAL_ADDR_BW,
  parameter int DIM   = TauCfg::DIM,
  parameter int V_BW  = $clog2(TauCfg::VECTOR_SIZE),
  parameter int IBW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  req_rdy,
  output logic [N_REQ-1:0]  req_ack,
  input  logic [GBW-1:0]    i_req_mofs   [N_REQ][DIM],
  input  logic [V_BW-1:0]   i_req_mpad   [N_REQ][DIM],
  input  logic [GBW-1:0]    i_req_mbound [N_REQ][DIM],
  input  logic [GBW-1:0]    i_req_mlast  [N_REQ][DIM],
  input  logic [GBW-1:0]    i_req_maddr  [N_REQ],
  output logic              mofs_rdy,
  input  logic              mofs_ack,
  output logic [GBW-1:0]    o_mofs   [DIM],
  output logic [V_BW-1:0]   o_mpad   [DIM],
  output logic [GBW-1:0]    o_mbound [DIM],
  output logic [GBW-1:0]    o_mlast  [DIM],
  output logic [GBW-1:0]    o_maddr,
  input  logic              row_rdy,
  input  logic              row_ack,
  input  logic              i_row_islast,
  output logic [IBW-1:0]    o_row_id,
  output logic              o_busy
);

  arb_state_t       state, state_nxt;
  logic [IBW-1:0]   ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [IBW-1:0]   pick_id;
  logic             pick_any;
  logic             grant_fire;

  RoundRobinPick #(.N_REQ(N_REQ), .IBW(IBW)) u_pick (
    .req   (req_rdy),
    .ptr   (ptr),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Row handshakes outside ST_BUSY are deliberately ignored.
  always_comb begin
    state_nxt  = state;
    req_ack    = '0;
    mofs_rdy   = 1'b0;
    o_busy     = 1'b1;
    grant_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy     = 1'b0;
        grant_fire = pick_any;
        // Gate with reset so no requester sees an ack while held in reset.
        req_ack    = i_rst ? pick_grant : '0;
        if (pick_any) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mofs_rdy = 1'b1;
        if (mofs_ack) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (row_rdy && row_ack && i_row_islast) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        o_busy    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr      <= '0;
      o_row_id <= '0;
      o_maddr  <= '0;
      for (int d = 0; d < DIM; d++) begin
        o_mofs[d]   <= '0;
        o_mpad[d]   <= '0;
        o_mbound[d] <= '0;
        o_mlast[d]  <= '0;
      end
    end else if (grant_fire) begin
      ptr      <= (pick_id == IBW'(N_REQ - 1)) ? '0 : pick_id + IBW'(1);
      o_row_id <= pick_id;
      o_maddr  <= i_req_maddr[pick_id];
      for (int d = 0; d < DIM; d++) begin
        o_mofs[d]   <= i_req_mofs[pick_id][d];
        o_mpad[d]   <= i_req_mpad[pick_id][d];
        o_mbound[d] <= i_req_mbound[pick_id][d];
        o_mlast[d]  <= i_req_mlast[pick_id][d];
      end
    end
  end

endmodule

// File: tb/tb_chunk_row_arbiter.sv
module tb_chunk_row_arbiter;
  import TauCfg::*;

  localparam int N_REQ = 2;
  localparam int GBW   = TauCfg::GLOBAL_ADDR_BW;
  localparam int DIM   = TauCfg::DIM;
  localparam int V_BW  = $clog2(TauCfg::VECTOR_SIZE);
  localparam int IBW   = 1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [N_REQ-1:0]  req_rdy;
  logic [N_REQ-1:0]  req_ack;
  logic [GBW-1:0]    i_req_mofs   [N_REQ][DIM];
  logic [V_BW-1:0]   i_req_mpad   [N_REQ][DIM];
  logic [GBW-1:0]    i_req_mbound [N_REQ][DIM];
  logic [GBW-1:0]    i_req_mlast  [N_REQ][DIM];
  logic [GBW-1:0]    i_req_maddr  [N_REQ];
  logic              mofs_rdy;
  logic              mofs_ack;
  logic [GBW-1:0]    o_mofs   [DIM];
  logic [V_BW-1:0]   o_mpad   [DIM];
  logic [GBW-1:0]    o_mbound [DIM];
  logic [GBW-1:0]    o_mlast  [DIM];
  logic [GBW-1:0]    o_maddr;
  logic              row_rdy;
  logic              row_ack;
  logic              i_row_islast;
  logic [IBW-1:0]    o_row_id;
  logic              o_busy;

  chunk_row_arbiter #(.N_REQ(N_REQ)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .req_rdy      (req_rdy),
    .req_ack      (req_ack),
    .i_req_mofs   (i_req_mofs),
    .i_req_mpad   (i_req_mpad),
    .i_req_mbound (i_req_mbound),
    .i_req_mlast  (i_req_mlast),
    .i_req_maddr  (i_req_maddr),
    .mofs_rdy     (mofs_rdy),
    .mofs_ack     (mofs_ack),
    .o_mofs       (o_mofs),
    .o_mpad       (o_mpad),
    .o_mbound     (o_mbound),
    .o_mlast      (o_mlast),
    .o_maddr      (o_maddr),
    .row_rdy      (row_rdy),
    .row_ack      (row_ack),
    .i_row_islast (i_row_islast),
    .o_row_id     (o_row_id),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_q[$];
  int ptr_m   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Push the expected winner and advance the bench's pointer model.
  task automatic expect_grant(input int id);
    exp_q.push_back(id);
    ptr_m = (id + 1) % N_REQ;
  endtask

  task automatic pop_check_grant(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk(tag, 64'(req_ack), 64'(1 << e));
  endtask

  // Generator model: accept the command once offered, then emit nrows rows,
  // checking that the owner id and address stay put the whole time.
  task automatic serve(input int nrows, input int id, input logic [GBW-1:0] addr);
    int n;
    n = 0;
    while (!mofs_rdy && n < 20) begin step(); n++; end
    if (!mofs_rdy) chk("mofs_rdy_timeout", 64'd0, 64'd1);
    mofs_ack = 1'b1;
    step();
    mofs_ack = 1'b0;
    #1;
    chk("busy_after_mofs", 64'(o_busy), 64'd1);
    chk("mofs_rdy_drop",   64'(mofs_rdy), 64'd0);
    for (int r = 0; r < nrows; r++) begin
      row_rdy      = 1'b1;
      row_ack      = 1'b1;
      i_row_islast = (r == nrows - 1);
      #1;
      chk("row_id_hold", 64'(o_row_id), 64'(id));
      chk("maddr_hold",  64'(o_maddr), 64'(addr));
      step();
      if (r != nrows - 1) chk("busy_midchunk", 64'(o_busy), 64'd1);
    end
    row_rdy      = 1'b0;
    row_ack      = 1'b0;
    i_row_islast = 1'b0;
  endtask

  initial begin
    i_rst        = 1'b0;
    req_rdy      = 2'b11;
    mofs_ack     = 1'b0;
    row_rdy      = 1'b0;
    row_ack      = 1'b0;
    i_row_islast = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      i_req_maddr[i] = GBW'(32'h200 + 32'h100 * i);
      for (int d = 0; d < DIM; d++) begin
        i_req_mofs[i][d]   = GBW'(16 * i + d + 1);
        i_req_mpad[i][d]   = V_BW'(i + d + 3);
        i_req_mbound[i][d] = GBW'(64 + 8 * i + d);
        i_req_mlast[i][d]  = GBW'(10 * i + d + 5);
      end
    end

    // Reset state, with requests present to show req_ack is forced low.
    #12;
    chk("rst_req_ack",  64'(req_ack), 64'd0);
    chk("rst_mofs_rdy", 64'(mofs_rdy), 64'd0);
    chk("rst_busy",     64'(o_busy), 64'd0);
    chk("rst_row_id",   64'(o_row_id), 64'd0);
    chk("rst_maddr",    64'(o_maddr), 64'd0);
    chk("rst_mlast0",   64'(o_mlast[0]), 64'd0);
    req_rdy = 2'b00;
    step();
    i_rst = 1'b1;
    step();

    // First grant: requester 0, maddr 0x100, mlast {1,2}.
    i_req_maddr[0]    = GBW'(32'h100);
    i_req_mlast[0][0] = GBW'(1);
    i_req_mlast[0][1] = GBW'(2);
    req_rdy = 2'b01;
    expect_grant(0);
    #1;
    pop_check_grant("gnt_first");
    chk("idle_mofs_rdy", 64'(mofs_rdy), 64'd0);
    step();
    req_rdy = 2'b00;
    #1;
    chk("first_mofs_rdy", 64'(mofs_rdy), 64'd1);
    chk("first_maddr",    64'(o_maddr), 64'h100);
    chk("first_mlast0",   64'(o_mlast[0]), 64'd1);
    chk("first_mlast1",   64'(o_mlast[1]), 64'd2);
    chk("first_mofs1",    64'(o_mofs[1]), 64'd2);
    chk("first_mpad0",    64'(o_mpad[0]), 64'd3);
    chk("first_mbound1",  64'(o_mbound[1]), 64'd65);
    chk("first_row_id",   64'(o_row_id), 64'd0);
    chk("first_busy",     64'(o_busy), 64'd1);

    // Hold off mofs_ack for 5 cycles; a spurious last-row handshake lands
    // in the middle and must be ignored.
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin row_rdy = 1'b1; row_ack = 1'b1; i_row_islast = 1'b1; end
      else        begin row_rdy = 1'b0; row_ack = 1'b0; i_row_islast = 1'b0; end
      step();
      chk("hold_mofs_rdy", 64'(mofs_rdy), 64'd1);
      chk("hold_maddr",    64'(o_maddr), 64'h100);
    end
    row_rdy = 1'b0; row_ack = 1'b0; i_row_islast = 1'b0;
    serve(2, 0, GBW'(32'h100));
    #1;
    chk("release_busy",    64'(o_busy), 64'd0);
    chk("release_req_ack", 64'(req_ack), 64'd0);

    // Both requesters continuously request; 3-row chunks; grants alternate.
    i_req_maddr[0] = GBW'(32'h200);
    req_rdy = 2'b11;
    for (int g = 0; g < 4; g++) expect_grant(ptr_m);
    for (int g = 0; g < 4; g++) begin
      int e;
      logic [GBW-1:0] a;
      e = exp_q[0];
      a = GBW'(32'h200 + 32'h100 * e);
      #1;
      pop_check_grant("gnt_alt");
      step();
      chk("alt_row_id", 64'(o_row_id), 64'(e));
      chk("alt_maddr",  64'(o_maddr), 64'(a));
      chk("alt_mofs0",  64'(o_mofs[0]), 64'(16 * e + 1));
      serve(3, e, a);
    end

    // ptr now 1; requester 1 withdraws, so requester 0 wins by wrap-around.
    req_rdy = 2'b01;
    expect_grant(0);
    #1;
    pop_check_grant("gnt_withdraw");
    step();
    req_rdy = 2'b00;
    n_wait_mofs();
    mofs_ack = 1'b1;
    step();
    mofs_ack = 1'b0;
    // Single-row chunk with row_ack delayed 3 cycles.
    row_rdy = 1'b1; i_row_islast = 1'b1; row_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("single_wait_busy", 64'(o_busy), 64'd1);
    end
    row_ack = 1'b1;
    req_rdy = 2'b10;
    expect_grant(1);
    step();
    row_rdy = 1'b0; row_ack = 1'b0; i_row_islast = 1'b0;
    #1;
    chk("single_release_busy", 64'(o_busy), 64'd0);
    pop_check_grant("gnt_after_single");
    step();
    req_rdy = 2'b11;
    chk("gap_mofs_rdy", 64'(mofs_rdy), 64'd1);
    chk("gap_row_id",   64'(o_row_id), 64'd1);
    mofs_ack = 1'b1;
    step();
    mofs_ack = 1'b0;
    row_rdy = 1'b1; row_ack = 1'b1; i_row_islast = 1'b0;
    step();
    row_rdy = 1'b0; row_ack = 1'b0;

    // Reset mid-chunk, asserted away from any clock edge.
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    #2;
    i_rst = 1'b0;
    #1;
    chk("midrst_busy",     64'(o_busy), 64'd0);
    chk("midrst_mofs_rdy", 64'(mofs_rdy), 64'd0);
    chk("midrst_row_id",   64'(o_row_id), 64'd0);
    chk("midrst_maddr",    64'(o_maddr), 64'd0);
    chk("midrst_req_ack",  64'(req_ack), 64'd0);
    #1;
    i_rst = 1'b1;
    ptr_m = 0;
    expect_grant(ptr_m);
    #1;
    pop_check_grant("gnt_after_rst");
    chk("leftover_q", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  task automatic n_wait_mofs();
    int n;
    n = 0;
    while (!mofs_rdy && n < 20) begin step(); n++; end
    chk("wait_mofs_rdy", 64'(mofs_rdy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
